score_note_sequencer: RTL

Sequences detected note events into the score renderer's note table. The block buffers `note_dec` events in a small FIFO and assigns each note the next free slot (staff, column). It commits table writes only during vertical blanking, so no frame ever shows a half-updated table. It also clears the page on request, or automatically when a note arrives on a full page. It sits between the pitch/duration detector and the VGA score renderer's note-table write port.

---
 rtl/score_note_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/score_note_sequencer.sv
// Buffers detected note events and commits them to the score renderer's note table
// during vertical blanking; also performs requested and automatic page clears.
module score_note_sequencer #(
    parameter int FIFO_DEPTH      = 4,
    parameter int NOTES_PER_STAFF = 13,
    parameter int NUM_STAFFS      = 4,
    parameter bit AUTO_CLEAR      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  note,
    input  logic [3:0]  duration,
    input  logic        note_dec,
    input  logic        vblank,
    input  logic        clear_req,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic [12:0] wr_data,
    output logic [5:0]  note_count,
    output logic [1:0]  staff_num,
    output logic [3:0]  col,
    output logic        page_full,
    output logic        busy,
    output logic        drop
);

    localparam int MAX_NOTES = NOTES_PER_STAFF * NUM_STAFFS;
    localparam int PW        = $clog2(FIFO_DEPTH);

    localparam logic [PW:0]   DEPTH_C      = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE_C    = (PW+1)'(1);
    localparam logic [PW:0]   CNT_ZERO_C   = (PW+1)'(0);
    localparam logic [PW-1:0] PTR_ONE_C    = PW'(1);
    localparam logic [3:0]    LAST_COL_C   = 4'(NOTES_PER_STAFF - 1);
    localparam logic [1:0]    LAST_STAFF_C = 2'(NUM_STAFFS - 1);
    localparam logic [5:0]    LAST_ADDR_C  = 6'(MAX_NOTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_WRITE   = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    function automatic logic letter_ok(input logic [3:0] letter);
        case (letter)
            4'b1100, 4'b1101, 4'b1110, 4'b1111,
            4'b1000, 4'b1010, 4'b1011: letter_ok = 1'b1;
            default:                   letter_ok = 1'b0;
        endcase
    endfunction

    // Anything that is not a single duration bit is treated as a quarter note.
    function automatic logic [3:0] fix_duration(input logic [3:0] dur);
        case (dur)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: fix_duration = dur;
            default:                            fix_duration = 4'b0010;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [11:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          clear_pend_q, clear_pend_d;
    logic [5:0]    clr_ptr_q, clr_ptr_d;
    logic [5:0]    note_count_q, note_count_d;
    logic [1:0]    staff_q, staff_d;
    logic [3:0]    col_q, col_d;
    logic          page_full_q, page_full_d;
    logic          wr_en_q, wr_en_d;
    logic [5:0]    wr_addr_q, wr_addr_d;
    logic [12:0]   wr_data_q, wr_data_d;
    logic          drop_q, drop_d;

    logic          letter_ok_s, room_s, push_s, pop_s, wr_drop_s, auto_pend_s, fifo_empties_s;
    logic [3:0]    dur_fix_s;
    logic [11:0]   head_s;

    // Next-state, write decision, capture and counter logic.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        note_count_d = note_count_q;
        staff_d      = staff_q;
        col_d        = col_q;
        page_full_d  = page_full_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = 6'd0;
        wr_data_d    = 13'd0;
        pop_s        = 1'b0;
        wr_drop_s    = 1'b0;
        auto_pend_s  = 1'b0;
        letter_ok_s  = letter_ok(note[7:4]);
        dur_fix_s    = fix_duration(duration);
        head_s       = fifo_mem_q[rd_ptr_q];
        // A same-cycle valid capture keeps the FIFO non-empty after the pop.
        fifo_empties_s = (cnt_q == CNT_ONE_C) && !(note_dec && letter_ok_s);

        case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    state_d = ST_CLEAR;
                end else if (cnt_q != CNT_ZERO_C) begin
                    state_d = ST_WAIT_VB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VB: begin
                if (vblank) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_WRITE: begin
                if (!vblank || clear_pend_q || (cnt_q == CNT_ZERO_C)) begin
                    state_d = ST_IDLE;
                end else if (page_full_q && AUTO_CLEAR) begin
                    auto_pend_s = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    pop_s = 1'b1;
                    if (page_full_q) begin
                        wr_drop_s = 1'b1;
                    end else begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = note_count_q;
                        wr_data_d    = {1'b1, head_s};
                        note_count_d = note_count_q + 6'd1;
                        if (col_q == LAST_COL_C) begin
                            col_d = 4'd0;
                            if (staff_q == LAST_STAFF_C) begin
                                staff_d     = 2'd0;
                                page_full_d = 1'b1;
                            end else begin
                                staff_d = staff_q + 2'd1;
                            end
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                    if (fifo_empties_s || clear_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_CLEAR: begin
                if (vblank) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_ptr_q;
                    wr_data_d = 13'd0;
                    if (clr_ptr_q == LAST_ADDR_C) begin
                        clr_ptr_d    = 6'd0;
                        note_count_d = 6'd0;
                        staff_d      = 2'd0;
                        col_d        = 4'd0;
                        page_full_d  = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + 6'd1;
                    end
                end else begin
                    clr_ptr_d = clr_ptr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        room_s = (cnt_q < DEPTH_C) || pop_s;
        push_s = note_dec && letter_ok_s && room_s;
        drop_d = (note_dec && !(letter_ok_s && room_s)) || wr_drop_s;

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE_C;
            2'b01:   cnt_d = cnt_q - CNT_ONE_C;
            default: cnt_d = cnt_q;
        endcase

        // Requests seen while clearing (or entering CLEAR) are absorbed.
        if ((state_q == ST_IDLE) && clear_pend_q) begin
            clear_pend_d = 1'b0;
        end else begin
            clear_pend_d = clear_pend_q || auto_pend_s || (clear_req && (state_q != ST_CLEAR));
        end
    end

    // State, FIFO, counters and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 12'd0;
            end
            rd_ptr_q     <= {PW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            cnt_q        <= CNT_ZERO_C;
            clear_pend_q <= 1'b0;
            clr_ptr_q    <= 6'd0;
            note_count_q <= 6'd0;
            staff_q      <= 2'd0;
            col_q        <= 4'd0;
            page_full_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 6'd0;
            wr_data_q    <= 13'd0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= {note, dur_fix_s};
                wr_ptr_q             <= wr_ptr_q + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
            end
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            clr_ptr_q    <= clr_ptr_d;
            note_count_q <= note_count_d;
            staff_q      <= staff_d;
            col_q        <= col_d;
            page_full_q  <= page_full_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            drop_q       <= drop_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign note_count = note_count_q;
    assign staff_num  = staff_q;
    assign col        = col_q;
    assign page_full  = page_full_q;
    assign busy       = (state_q != ST_IDLE) || (cnt_q != CNT_ZERO_C);
    assign drop       = drop_q;

endmodule
